div_8bit_seq: RTL



---
 rtl/div_8bit_seq_pkg.sv | 19 +
 rtl/div_8bit_seq_step.sv | 42 ++++
 rtl/div_8bit_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/div_8bit_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_8bit_seq_pkg
// Shared definitions for the sequential restoring divider: default operand
// width, FSM state encoding and the quotient reported on a zero divisor.
// -----------------------------------------------------------------------------
package div_8bit_seq_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    // Quotient reported when the divisor is zero: all ones, as RISC-V DIVU does.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage : div_8bit_seq_pkg

// File: rtl/div_8bit_seq_step.sv
// -----------------------------------------------------------------------------
// div_8bit_seq_step
// One combinational restoring-division step (the "div_step" of the divider).
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor; the borrow selects between the trial and the shifted remainder.
//
// Ports:
//   i_rem       partial remainder R before the step (WIDTH+1 bits)
//   i_bit       dividend bit shifted into R (MSB of the quotient register)
//   i_divisor   divisor (WIDTH bits)
//   o_rem       partial remainder after the step (WIDTH+1 bits)
//   o_qbit      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_8bit_seq_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Shift-and-subtract with borrow select.
    always_comb begin
        w_shifted = {i_rem[WIDTH-1:0], i_bit};
        w_trial   = w_shifted - {1'b0, i_divisor};
        // If the remainder's top bit was already set, the true shifted value
        // exceeds any divisor, so the subtraction must be taken regardless of
        // the trial MSB. In normal operation R < divisor keeps that bit clear.
        o_qbit    = i_rem[WIDTH] | ~w_trial[WIDTH];
        if (o_qbit) begin
            o_rem = w_trial;
        end else begin
            o_rem = w_shifted;
        end
    end

endmodule : div_8bit_seq_step

// File: rtl/div_8bit_seq.sv
// -----------------------------------------------------------------------------
// div_8bit_seq
// Sequential unsigned restoring divider, one quotient bit per clock.
// Serves the DIV/DIVU path beside the execute-stage ALU.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset (discards any in-flight op)
//   i_start        request; only sampled while not busy (IDLE or DONE)
//   i_dividend     unsigned dividend, captured on an accepted start
//   i_divisor      unsigned divisor, captured on an accepted start
//   o_busy         high while iterating
//   o_done         one-cycle pulse, results valid
//   o_quotient     quotient, held until replaced by a later result
//   o_remainder    remainder, held until replaced by a later result
//   o_div_by_zero  set with o_done when the captured divisor was zero
// Latency: WIDTH+1 cycles from accepted start to o_done (1 cycle for /0).
// -----------------------------------------------------------------------------
module div_8bit_seq
    import div_8bit_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    div_state_t       w_state_nx;
    logic [CW-1:0]    w_count_nx;
    logic [WIDTH:0]   w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_divisor_nx;
    logic [WIDTH-1:0] w_quotient_nx;
    logic [WIDTH-1:0] w_remainder_nx;
    logic             w_dbz_nx;
    logic             w_accept;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_qbit;

    div_8bit_seq_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_q[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    // A start is accepted only when not iterating (IDLE or DONE).
    always_comb begin
        w_accept = 1'b0;
        if (i_start && (r_state == ST_IDLE || r_state == ST_DONE)) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_nx     = r_state;
        w_count_nx     = r_count;
        w_rem_nx       = r_rem;
        w_q_nx         = r_q;
        w_divisor_nx   = r_divisor;
        w_quotient_nx  = r_quotient;
        w_remainder_nx = r_remainder;
        w_dbz_nx       = r_dbz;
        if (w_accept) begin
            w_divisor_nx = i_divisor;
            if (i_divisor == {WIDTH{1'b0}}) begin
                // Zero divisor skips iteration and reports immediately.
                w_state_nx     = ST_DONE;
                w_quotient_nx  = DBZ_QUOTIENT;
                w_remainder_nx = i_dividend;
                w_dbz_nx       = 1'b1;
            end else begin
                w_state_nx = ST_RUN;
                w_count_nx = {CW{1'b0}};
                w_rem_nx   = {(WIDTH+1){1'b0}};
                w_q_nx     = i_dividend;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_IDLE;
                end
                ST_RUN: begin
                    w_rem_nx   = w_step_rem;
                    w_q_nx     = {r_q[WIDTH-2:0], w_step_qbit};
                    w_count_nx = r_count + CW'(1);
                    if (r_count == LAST_ITER) begin
                        // Last step: publish straight from the step result so
                        // done and the results appear on the same edge.
                        w_state_nx     = ST_DONE;
                        w_quotient_nx  = {r_q[WIDTH-2:0], w_step_qbit};
                        w_remainder_nx = w_step_rem[WIDTH-1:0];
                        w_dbz_nx       = 1'b0;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_state_nx = ST_IDLE;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_count     <= {CW{1'b0}};
            r_rem       <= {(WIDTH+1){1'b0}};
            r_q         <= {WIDTH{1'b0}};
            r_divisor   <= {WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= {WIDTH{1'b0}};
            r_remainder <= {WIDTH{1'b0}};
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_count     <= w_count_nx;
            r_rem       <= w_rem_nx;
            r_q         <= w_q_nx;
            r_divisor   <= w_divisor_nx;
            r_busy      <= (w_state_nx == ST_RUN);
            r_done      <= (w_state_nx == ST_DONE);
            r_quotient  <= w_quotient_nx;
            r_remainder <= w_remainder_nx;
            r_dbz       <= w_dbz_nx;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dbz;

endmodule : div_8bit_seq
